// File: rtl/noc_injector.sv
// -----------------------------------------------------------------------------
// noc_injector
// Packetising transmitter for one router local input port of the ring NoC.
// It accepts a command (destination, body length) and emits a header flit.
// It then streams body words from a valid/ready interface as body flits.
// It throttles itself against the local FIFO's full/almost_full flags and
// counts completed packets.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (accepted only in IDLE)
//   cmd_dest, cmd_len       destination router id, number of body flits
//   data_valid/data_ready   body word handshake (data_ready is combinational)
//   data_in                 body payload, WIDTH-2 bits
//   write, dataOut          registered write strobe and flit to the NoC FIFO
//   full, almost_full       FIFO status from the NoC local input
//   busy                    packet in progress or flit still on write
//   pkt_count               completed packets, wraps 255 -> 0
//
// Header layout: [WIDTH-1:WIDTH-2]=dest, [WIDTH-3:WIDTH-4]=SRC_ID,
// [LENWIDTH-1:0]=len, other bits zero (LENWIDTH must not exceed WIDTH-4).
// Body layout:   {dest, data_in}.
// -----------------------------------------------------------------------------
module noc_injector #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LENWIDTH = 4,
  parameter logic [1:0]  SRC_ID   = 2'b00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_dest,
  input  logic [LENWIDTH-1:0] cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [WIDTH-3:0]    data_in,
  output logic                write,
  output logic [WIDTH-1:0]    dataOut,
  input  logic                full,
  input  logic                almost_full,
  output logic                busy,
  output logic [7:0]          pkt_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_next;

  logic [1:0]          r_dest;
  logic [LENWIDTH-1:0] r_len;
  logic [LENWIDTH-1:0] r_cnt;
  logic                r_write;
  logic [WIDTH-1:0]    r_data;
  logic [CNT_W-1:0]    r_pkt_count;

  logic                w_can_write;
  logic                w_cmd_ready;
  logic                w_data_ready;
  logic                w_accept;
  logic                w_issue;
  logic                w_cnt_dec;
  logic                w_pkt_done;
  logic [WIDTH-1:0]    w_flit;
  logic [WIDTH-1:0]    w_head_flit;
  logic [WIDTH-1:0]    w_body_flit;

  // The flit on write this cycle is not yet counted by the FIFO, so with
  // almost_full it already occupies the last free slot.
  assign w_can_write = ~full & ~(almost_full & r_write);

  // Header flit assembly from the latched command.
  always_comb begin
    w_head_flit                 = '0;
    w_head_flit[WIDTH-1 -: 2]   = r_dest;
    w_head_flit[WIDTH-3 -: 2]   = SRC_ID;
    w_head_flit[LENWIDTH-1:0]   = r_len;
  end

  assign w_body_flit = {r_dest, data_in};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (w_can_write) begin
          w_state_next = (r_len == '0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        if (data_valid && w_can_write && (r_cnt == LENWIDTH'(1))) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output / issue decode.
  always_comb begin
    w_cmd_ready  = 1'b0;
    w_data_ready = 1'b0;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_cnt_dec    = 1'b0;
    w_pkt_done   = 1'b0;
    w_flit       = w_head_flit;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        w_accept    = cmd_valid;
      end
      ST_HEAD: begin
        if (w_can_write) begin
          w_issue    = 1'b1;
          w_flit     = w_head_flit;
          w_pkt_done = (r_len == '0);
        end
      end
      ST_BODY: begin
        w_data_ready = w_can_write;
        if (data_valid && w_can_write) begin
          w_issue    = 1'b1;
          w_flit     = w_body_flit;
          w_cnt_dec  = 1'b1;
          w_pkt_done = (r_cnt == LENWIDTH'(1));
        end
      end
      default: begin
        w_cmd_ready = 1'b0;
      end
    endcase
  end

  // Command latch, remaining-body counter, flit output register, packet counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dest      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_data      <= '0;
      r_pkt_count <= '0;
    end else begin
      r_write <= w_issue;
      if (w_issue) begin
        r_data <= w_flit;
      end
      if (w_accept) begin
        r_dest <= cmd_dest;
        r_len  <= cmd_len;
        r_cnt  <= cmd_len;
      end else if (w_cnt_dec) begin
        r_cnt  <= r_cnt - LENWIDTH'(1);
      end
      if (w_pkt_done) begin
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign data_ready = w_data_ready;
  assign write      = r_write;
  assign dataOut    = r_data;
  assign pkt_count  = r_pkt_count;
  assign busy       = (r_state != ST_IDLE) | r_write;

endmodule

// File: doc/noc_injector.md
Name: noc_injector

Overview:
- Packetising transmitter that drives one local write port of the 4-router ring NoC, i.e. the write/dataIn/full/almost_full side of a router's local input FIFO.
- Accepts a command (destination router, body length), emits a header flit, then streams body words taken from a valid/ready data interface as body flits.
- Honours FIFO backpressure from full and almost_full; counts completed packets.
- One instance per router local port; SRC_ID identifies the attached router.

Parameters:
- WIDTH, 16, flit width; must match NoC WIDTH.
- LENWIDTH, 4, width of the body-length field (0..2^LENWIDTH-1 body flits).
- SRC_ID, 2'b00, 2-bit id of the attached router, inserted in header flits.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_dest  input  2  destination router id.
- cmd_len  input  LENWIDTH  number of body flits.
- data_valid  input  1  body word valid.
- data_ready  output  1  body word consumed when data_valid && data_ready.
- data_in  input  WIDTH-2  body payload.
- write  output  1  write strobe to NoC local input (registered).
- dataOut  output  WIDTH  flit to NoC local input (registered).
- full  input  1  NoC local FIFO full.
- almost_full  input  1  NoC local FIFO has one free slot.
- busy  output  1  packet in progress or flit pending on write.
- pkt_count  output  8  completed packets, wraps 255->0.

Behaviour:
- Reset (async, any time incl. mid-packet): state=IDLE, write=0, dataOut=0, pkt_count=0, latched dest/len/counter=0. A partial packet is abandoned and never resumed.
- Header flit: [WIDTH-1:WIDTH-2]=dest, [WIDTH-3:WIDTH-4]=SRC_ID, [LENWIDTH-1:0]=len. All other bits 0.
- Body flit: {dest, data_in}.
- can_write = !full && !(almost_full && write). The registered write is the flit issued last cycle that the FIFO has not yet counted.
- Issue timing: a flit issued in cycle t appears on write/dataOut in cycle t+1 for exactly one cycle. When no flit is issued, write=0 and dataOut holds its last value.
- FSM states: IDLE, HEAD, BODY.
- IDLE:
  - cmd_ready=1, data_ready=0.
  - On cmd_valid: latch cmd_dest and cmd_len, set cnt=cmd_len, go to HEAD.
- HEAD:
  - cmd_ready=0, data_ready=0.
  - When can_write: issue the header flit. If len==0, increment pkt_count and go to IDLE; else go to BODY.
  - When !can_write: stall in HEAD with no flit issued.
- BODY:
  - data_ready = can_write (combinational).
  - On data_valid && can_write: issue a body flit and decrement cnt. If cnt was 1, increment pkt_count and go to IDLE.
  - When data_valid=0, or can_write=0: hold state with no flit issued.
- cmd_ready and data_ready are never both 1. Commands presented outside IDLE are not accepted and must be held by the source.
- A new command may be accepted in the cycle after returning to IDLE, so there is 1 idle cycle between packets.
- busy = (state!=IDLE) || write.
- cmd_dest==SRC_ID (loopback) is legal and handled identically.

Test Plan:
- Assert reset mid-run, then release -> cmd_ready=1, data_ready=0, write=0, dataOut=16'h0000, pkt_count=0, busy=0.
- SRC_ID=0, cmd dest=2 len=3, data 14'h0011/0012/0013 always valid, full=almost_full=0 -> write high 4 consecutive cycles with dataOut 16'h8003, 16'h8011, 16'h8012, 16'h8013; pkt_count=1; cmd_ready back to 1 one cycle after the last issue.
- As above, but full=1 for 5 cycles after the header -> data_ready=0 and write=0 during the stall; after full drops the three body flits follow back-to-back with unchanged values.
- almost_full=1, full=0 held for a len=4 packet -> write pattern 1,0,1,0,... so there are never two consecutive writes; all 5 flits are delivered in order.
- SRC_ID=1, cmd dest=3 len=0 -> single flit 16'hD000; pkt_count increments by 1; no data_ready pulse. Repeat 256 times -> pkt_count wraps to 0.
- Reset asserted after 2 of 5 body flits -> write=0 immediately (async), state IDLE. The next command dest=1 len=1 produces header 16'h4001 with no leftover flits from the abandoned packet.
